// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   - hazard_state_t : hazard controller state encoding (also driven out on HazardState)
//   - opcode constants shared by StallDetection and the instruction decoder
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL_ID = 2'b01,
    STALL_EX = 2'b10,
    HALT     = 2'b11
  } hazard_state_t;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] LUI   = 6'b001111;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

endpackage

// File: rtl/pipeline_hazard_control_if.sv
// Hazard-control bundle between StallDetection/ID resolution and the pipeline registers.
//   master : drives the hazard requests (IDStall, EXStall, IDBranchTaken, IDJump),
//            receives the pipeline-register controls, state and counters.
//   slave  : the hazard controller itself.
interface pipeline_hazard_control_if #(
  parameter int CNT_W = 16
);
  logic             IDStall;
  logic             EXStall;
  logic             IDBranchTaken;
  logic             IDJump;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXWrite;
  logic             IDEXBubble;
  logic             EXMEMBubble;
  logic [1:0]       HazardState;
  logic             HazardError;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCycles;

  modport master (
    output IDStall, EXStall, IDBranchTaken, IDJump,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
    input  HazardState, HazardError, StallCycles, FlushCycles
  );

  modport slave (
    input  IDStall, EXStall, IDBranchTaken, IDJump,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXBubble, EXMEMBubble,
    output HazardState, HazardError, StallCycles, FlushCycles
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per enabled cycle and sticks at all-ones.
//   clk   : counting clock
//   rst_n : asynchronous active-low clear
//   en    : increment request for this cycle
//   cnt   : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_control.sv
// Hazard controller for the 5-stage MIPS pipeline. Turns stall and branch/jump
// requests into write-enable, bubble and flush controls for the PC and the
// IF/ID, ID/EX and EX/MEM registers, with a stall-length watchdog and
// saturating stall/flush counters.
//   clk   : pipeline clock
//   reset : asynchronous active-low reset
//   hz    : hazard bundle (requests in; controls, HazardState, HazardError, counters out)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | last cycle was not a stall
//   STALL_ID | last cycle stalled on an unresolved ID operand
//   STALL_EX | last cycle stalled on a load feeding EX
//   HALT     | watchdog tripped; pipeline frozen until reset
module pipeline_hazard_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_hazard_control_if.slave    hz
);

  // Run length never exceeds MAX_STALL (<= 15), so four bits are enough.
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_STALL - 1);

  hazard_state_t state_q, state_d;
  logic [3:0]    run_q, run_d;
  logic          err_q, err_d;

  logic          stall;
  logic          flush_req;
  logic          halted;
  logic          stall_cnt_en;
  logic          flush_cnt_en;

  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_write;
  logic          idex_bubble;
  logic          exmem_bubble;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  assign stall     = hz.EXStall | hz.IDStall;
  assign flush_req = hz.IDBranchTaken | hz.IDJump;
  assign halted    = (state_q == HALT);

  // Zero-latency controls; priority HALT > EXStall > IDStall > branch/jump.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (halted) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (hz.EXStall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (hz.IDStall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    err_d   = err_q;
    if (!halted) begin
      if (stall) begin
        run_d = run_q + 4'd1;
        // The stall that reaches the limit is itself counted, then we freeze.
        if (run_q == RUN_LIMIT) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else if (hz.EXStall) begin
          state_d = STALL_EX;
        end else begin
          state_d = STALL_ID;
        end
      end else begin
        run_d   = 4'd0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      run_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  // A branch under a stall is not flushed, so it is not counted either.
  assign stall_cnt_en = !halted && stall;
  assign flush_cnt_en = !halted && !stall && flush_req;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (stall_cnt_en),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (flush_cnt_en),
    .cnt   (flush_cnt)
  );

  assign hz.PCWrite     = pc_write;
  assign hz.IFIDWrite   = ifid_write;
  assign hz.IFIDFlush   = ifid_flush;
  assign hz.IDEXWrite   = idex_write;
  assign hz.IDEXBubble  = idex_bubble;
  assign hz.EXMEMBubble = exmem_bubble;
  assign hz.HazardState = state_q;
  assign hz.HazardError = err_q;
  assign hz.StallCycles = stall_cnt;
  assign hz.FlushCycles = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
module tb_pipeline_hazard_control;
  import pipeline_ctrl_pkg::*;

  localparam int MAX_STALL = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_control_if #(.CNT_W(16)) hz_a ();
  pipeline_hazard_control_if #(.CNT_W(4))  hz_b ();

  pipeline_hazard_control #(.MAX_STALL(MAX_STALL), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_a.slave)
  );

  pipeline_hazard_control #(.MAX_STALL(MAX_STALL), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_b.slave)
  );

  // ctl bits: PCWrite IFIDWrite IFIDFlush IDEXWrite IDEXBubble EXMEMBubble
  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } snap_t;

  snap_t      q_a[$];
  logic [4:0] q_b[$];   // {IFIDFlush, FlushCycles}

  int total = 0;
  int bad   = 0;

  // Reference model of dut_a
  int   m_state, m_run, m_sc, m_fc;
  logic m_err;
  logic in_id, in_ex, in_br, in_j;

  task automatic model_reset();
    m_state = 0; m_run = 0; m_sc = 0; m_fc = 0; m_err = 1'b0;
  endtask

  function automatic snap_t model_expect();
    snap_t e;
    if (m_state == 3)          e.ctl = 6'b000000;
    else if (in_ex)            e.ctl = 6'b000001;
    else if (in_id)            e.ctl = 6'b000110;
    else if (in_br || in_j)    e.ctl = 6'b111100;
    else                       e.ctl = 6'b110100;
    e.st  = 2'(m_state);
    e.err = m_err;
    e.sc  = 16'(m_sc);
    e.fc  = 16'(m_fc);
    return e;
  endfunction

  task automatic model_clock();
    if (m_state != 3) begin
      if (in_id || in_ex) begin
        if (m_sc < 65535) m_sc++;
        if (m_run == MAX_STALL - 1) begin
          m_state = 3;
          m_err   = 1'b1;
        end else begin
          m_state = in_ex ? 2 : 1;
        end
        m_run++;
      end else begin
        m_run   = 0;
        m_state = 0;
        if ((in_br || in_j) && m_fc < 65535) m_fc++;
      end
    end
  endtask

  function automatic snap_t sample_a();
    snap_t s;
    s.ctl = {hz_a.PCWrite, hz_a.IFIDWrite, hz_a.IFIDFlush,
             hz_a.IDEXWrite, hz_a.IDEXBubble, hz_a.EXMEMBubble};
    s.st  = hz_a.HazardState;
    s.err = hz_a.HazardError;
    s.sc  = hz_a.StallCycles;
    s.fc  = hz_a.FlushCycles;
    return s;
  endfunction

  // Drive one cycle of requests on dut_a (called at negedge) and queue the expectation.
  task automatic drive_a(input logic id, input logic ex, input logic br, input logic j);
    in_id = id; in_ex = ex; in_br = br; in_j = j;
    hz_a.IDStall = id; hz_a.EXStall = ex; hz_a.IDBranchTaken = br; hz_a.IDJump = j;
    #1;
    q_a.push_back(model_expect());
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t e, o;
    reset = 1'b0;
    hz_b.IDStall = 0; hz_b.EXStall = 0; hz_b.IDBranchTaken = 0; hz_b.IDJump = 0;
    model_reset();
    drive_a(0, 0, 0, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_held obs=%h exp=%h", o, e); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_a(0, 0, 0, 0);
      e = q_a.pop_front(); o = sample_a(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_idle%0d obs=%h exp=%h", i, o, e); end
      advance();
    end
  endtask

  task automatic test_id_stall();
    snap_t e, o;
    drive_a(1, 0, 0, 0);
    drive_a(0, 0, 0, 0);
    drive_a(0, 0, 0, 0);
    q_a.delete();
    drive_a(1, 0, 0, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL id_stall_ctl obs=%h exp=%h", o, e); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive_a(0, 0, 0, 0);
      e = q_a.pop_front(); o = sample_a(); total++;
      if (o !== e) begin bad++; $display("FAIL id_stall_after%0d obs=%h exp=%h", i, o, e); end
      advance();
    end
  endtask

  task automatic test_ex_stall();
    snap_t e, o;
    drive_a(1, 1, 1, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL ex_stall_ctl obs=%h exp=%h", o, e); end
    advance();
    drive_a(0, 0, 0, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL ex_stall_state obs=%h exp=%h", o, e); end
    advance();
  endtask

  task automatic test_branch_flush();
    snap_t e, o;
    logic [3:0] pat [4] = '{4'b1010, 4'b0010, 4'b0001, 4'b0011};  // {id,ex,br,j}
    for (int i = 0; i < 4; i++) begin
      drive_a(pat[i][3], pat[i][2], pat[i][1], pat[i][0]);
      e = q_a.pop_front(); o = sample_a(); total++;
      if (o !== e) begin bad++; $display("FAIL branch%0d obs=%h exp=%h", i, o, e); end
      advance();
    end
    drive_a(0, 0, 0, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL branch_count obs=%h exp=%h", o, e); end
    advance();
  endtask

  // Mixed stall types up to one short of the limit must not trip the watchdog.
  task automatic test_back_to_back();
    snap_t e, o;
    logic [1:0] seq [6] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00};  // {id,ex}
    for (int i = 0; i < 6; i++) begin
      drive_a(seq[i][1], seq[i][0], 1'b0, 1'b1);
      e = q_a.pop_front(); o = sample_a(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b%0d obs=%h exp=%h", i, o, e); end
      advance();
    end
  endtask

  task automatic test_watchdog();
    snap_t e, o;
    logic [1:0] seq [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 7; i++) begin
      drive_a(seq[i][1], seq[i][0], 1'b0, 1'b0);
      e = q_a.pop_front(); o = sample_a(); total++;
      if (o !== e) begin bad++; $display("FAIL watchdog%0d obs=%h exp=%h", i, o, e); end
      advance();
    end
    drive_a(0, 0, 1, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e || o.st !== 2'b11 || o.err !== 1'b1 || o.sc !== 16'(m_sc))
      begin bad++; $display("FAIL halt_hold obs=%h exp=%h", o, e); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    q_a.push_back(model_expect());
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL async_reset obs=%h exp=%h", o, e); end
    @(negedge clk);
    reset = 1'b1;
    drive_a(0, 0, 0, 0);
    e = q_a.pop_front(); o = sample_a(); total++;
    if (o !== e) begin bad++; $display("FAIL post_reset obs=%h exp=%h", o, e); end
    advance();
  endtask

  task automatic test_saturation();
    logic [4:0] e, o;
    hz_b.IDJump = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      q_b.push_back({1'b1, 4'((i > 15) ? 15 : i)});
      e = q_b.pop_front(); o = {hz_b.IFIDFlush, hz_b.FlushCycles}; total++;
      if (o !== e) begin bad++; $display("FAIL sat%0d obs=%h exp=%h", i, o, e); end
      @(posedge clk);
      @(negedge clk);
    end
    hz_b.IDJump = 1'b0;
    #1;
    q_b.push_back({1'b0, 4'hF});
    e = q_b.pop_front(); o = {hz_b.IFIDFlush, hz_b.FlushCycles}; total++;
    if (o !== e) begin bad++; $display("FAIL sat_final obs=%h exp=%h", o, e); end
  endtask

  initial begin
    hz_a.IDStall = 0; hz_a.EXStall = 0; hz_a.IDBranchTaken = 0; hz_a.IDJump = 0;
    @(negedge clk);
    test_reset();
    test_id_stall();
    test_ex_stall();
    test_branch_flush();
    test_back_to_back();
    test_watchdog();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
